// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: arbitrates between a write-command FIFO and a read-command
// FIFO and issues one SPI transfer at a time. Reads return the received word
// through a response FIFO. A watchdog abandons transfers that never complete.
//
// Ports:
//   clk_i, rst_n_i                  clock, asynchronous active-low reset
//   wr_cmd_valid_i/data_i/rd_o      write-command FIFO (not empty, head, pop)
//   rd_cmd_valid_i/data_i/rd_o      read-command FIFO (not empty, head, pop)
//   rsp_full_i, rsp_wr_o, rsp_data_o response FIFO (full, push, word)
//   spi_start_o, spi_tx_data_o      one-cycle start and word to shift out
//   spi_done_i, spi_rx_data_i       one-cycle completion and received word
//   busy_o                          high whenever the scheduler is not idle
//   timeout_o                       one-cycle pulse on watchdog expiry
//   grant_rd_o                      type of current/last transfer (1 = read)
module spi_xfer_sched #(
    parameter int unsigned G_WORD_LENGTH = 32,
    parameter int unsigned G_TIMEOUT     = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_cmd_valid_i,
    input  logic [G_WORD_LENGTH-1:0] wr_cmd_data_i,
    output logic                     wr_cmd_rd_o,
    input  logic                     rd_cmd_valid_i,
    input  logic [G_WORD_LENGTH-1:0] rd_cmd_data_i,
    output logic                     rd_cmd_rd_o,
    input  logic                     rsp_full_i,
    output logic                     rsp_wr_o,
    output logic [G_WORD_LENGTH-1:0] rsp_data_o,
    output logic                     spi_start_o,
    output logic [G_WORD_LENGTH-1:0] spi_tx_data_o,
    input  logic                     spi_done_i,
    input  logic [G_WORD_LENGTH-1:0] spi_rx_data_i,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic                     grant_rd_o
);

    localparam int unsigned CntW = (G_TIMEOUT < 1) ? 1 : $clog2(G_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(G_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StResp
    } state_e;

    state_e                   state_q, state_d;
    logic                     grant_rd_q, grant_rd_d;
    logic [G_WORD_LENGTH-1:0] tx_data_q, tx_data_d;
    logic [G_WORD_LENGTH-1:0] rsp_data_q, rsp_data_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     start_q, start_d;

    logic wr_elig;
    logic rd_elig;

    assign wr_elig = wr_cmd_valid_i;
    // A read is only taken when its response is guaranteed somewhere to go.
    assign rd_elig = rd_cmd_valid_i & ~rsp_full_i;

    always_comb begin
        state_d     = state_q;
        grant_rd_d  = grant_rd_q;
        tx_data_d   = tx_data_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        wr_cmd_rd_o = 1'b0;
        rd_cmd_rd_o = 1'b0;
        rsp_wr_o    = 1'b0;
        timeout_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Round-robin: on contention the type not granted last wins.
                if (wr_elig && (!rd_elig || grant_rd_q)) begin
                    wr_cmd_rd_o = 1'b1;
                    tx_data_d   = wr_cmd_data_i;
                    grant_rd_d  = 1'b0;
                    state_d     = StIssue;
                end else if (rd_elig) begin
                    rd_cmd_rd_o = 1'b1;
                    tx_data_d   = rd_cmd_data_i;
                    grant_rd_d  = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // Done takes priority over a coincident watchdog expiry.
                if (spi_done_i) begin
                    if (grant_rd_q) begin
                        rsp_data_d = spi_rx_data_i;
                        state_d    = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == TimeoutVal) begin
                    timeout_o = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                if (!rsp_full_i) begin
                    rsp_wr_o = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            grant_rd_q <= 1'b1;
            tx_data_q  <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_rd_q <= grant_rd_d;
            tx_data_q  <= tx_data_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
        end
    end

    assign spi_start_o   = start_q;
    assign spi_tx_data_o = tx_data_q;
    assign rsp_data_o    = rsp_data_q;
    assign grant_rd_o    = grant_rd_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Scoreboard bench for spi_xfer_sched: a transaction-level model predicts
// each pop, start, response and timeout with its cycle; a negedge monitor
// pops and compares whenever the DUT presents one of those events.
module tb_spi_xfer_sched;
    localparam int unsigned W     = 32;
    localparam int unsigned T     = 15;
    localparam int          Never = 32'h7fff_ffff;

    logic         clk_i          = 1'b0;
    logic         rst_n_i        = 1'b1;
    logic         wr_cmd_valid_i = 1'b0;
    logic [W-1:0] wr_cmd_data_i  = '0;
    logic         wr_cmd_rd_o;
    logic         rd_cmd_valid_i = 1'b0;
    logic [W-1:0] rd_cmd_data_i  = '0;
    logic         rd_cmd_rd_o;
    logic         rsp_full_i     = 1'b0;
    logic         rsp_wr_o;
    logic [W-1:0] rsp_data_o;
    logic         spi_start_o;
    logic [W-1:0] spi_tx_data_o;
    logic         spi_done_i     = 1'b0;
    logic [W-1:0] spi_rx_data_i  = '0;
    logic         busy_o;
    logic         timeout_o;
    logic         grant_rd_o;

    always #5 clk_i = ~clk_i;

    spi_xfer_sched #(
        .G_WORD_LENGTH(W),
        .G_TIMEOUT    (T)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .wr_cmd_valid_i(wr_cmd_valid_i),
        .wr_cmd_data_i (wr_cmd_data_i),
        .wr_cmd_rd_o   (wr_cmd_rd_o),
        .rd_cmd_valid_i(rd_cmd_valid_i),
        .rd_cmd_data_i (rd_cmd_data_i),
        .rd_cmd_rd_o   (rd_cmd_rd_o),
        .rsp_full_i    (rsp_full_i),
        .rsp_wr_o      (rsp_wr_o),
        .rsp_data_o    (rsp_data_o),
        .spi_start_o   (spi_start_o),
        .spi_tx_data_o (spi_tx_data_o),
        .spi_done_i    (spi_done_i),
        .spi_rx_data_i (spi_rx_data_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .grant_rd_o    (grant_rd_o)
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
        bit           rd;
    } exp_t;

    exp_t exp_pop[$];
    exp_t exp_start[$];
    exp_t exp_rsp[$];
    exp_t exp_to[$];

    logic [W-1:0] wq[$];
    logic [W-1:0] rq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit in_reset = 1'b1;
    bit pop_w    = 1'b0;
    bit pop_r    = 1'b0;

    // Transaction-level model state.
    bit           exp_busy     = 1'b0;
    bit           in_xfer      = 1'b0;
    bit           m_last_rd    = 1'b1;
    bit           m_rd         = 1'b0;
    bit           m_has_done   = 1'b0;
    bit           m_rsp_pend   = 1'b0;
    bit           force_nodone = 1'b0;
    bit           full_mode    = 1'b0;
    int           m_g          = 0;
    int           m_done       = 0;
    int           m_end        = 0;
    int           m_free       = 0;
    logic [W-1:0] m_rx         = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic note_missing(input string name, input int want);
        checks++;
        failures++;
        $display("FAIL %s: required at cycle %0d, still absent at cycle %0d", name, want, cyc);
    endtask

    task automatic note_unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle %0d: got an event, required none", name, cyc);
    endtask

    // Monitor: also records FIFO pops so the FIFO models can follow the DUT.
    always @(negedge clk_i) begin : mon
        exp_t e;
        pop_w <= wr_cmd_rd_o;
        pop_r <= rd_cmd_rd_o;
        if (!in_reset && rst_n_i) begin
            if (exp_pop.size() != 0 && exp_pop[0].cyc < cyc) begin
                note_missing("missing_pop", exp_pop[0].cyc);
                void'(exp_pop.pop_front());
            end
            if (exp_start.size() != 0 && exp_start[0].cyc < cyc) begin
                note_missing("missing_start", exp_start[0].cyc);
                void'(exp_start.pop_front());
            end
            if (exp_rsp.size() != 0 && exp_rsp[0].cyc < cyc) begin
                note_missing("missing_rsp", exp_rsp[0].cyc);
                void'(exp_rsp.pop_front());
            end
            if (exp_to.size() != 0 && exp_to[0].cyc < cyc) begin
                note_missing("missing_timeout", exp_to[0].cyc);
                void'(exp_to.pop_front());
            end

            chk("dual_pop", 64'(wr_cmd_rd_o & rd_cmd_rd_o), 64'd0);
            chk("busy", 64'(busy_o), 64'(exp_busy));

            if (wr_cmd_rd_o || rd_cmd_rd_o) begin
                if (exp_pop.size() == 0) note_unexpected("unexpected_pop");
                else begin
                    e = exp_pop.pop_front();
                    chk("pop_cycle", 64'(cyc), 64'(e.cyc));
                    chk("pop_is_read", 64'(rd_cmd_rd_o), 64'(e.rd));
                end
            end
            if (spi_start_o) begin
                if (exp_start.size() == 0) note_unexpected("unexpected_start");
                else begin
                    e = exp_start.pop_front();
                    chk("start_cycle", 64'(cyc), 64'(e.cyc));
                    chk("start_tx_data", 64'(spi_tx_data_o), 64'(e.data));
                    chk("start_grant_rd", 64'(grant_rd_o), 64'(e.rd));
                end
            end
            if (rsp_wr_o) begin
                if (exp_rsp.size() == 0) note_unexpected("unexpected_rsp");
                else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
                end
            end
            if (timeout_o) begin
                if (exp_to.size() == 0) note_unexpected("unexpected_timeout");
                else begin
                    e = exp_to.pop_front();
                    chk("timeout_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // One clock cycle: follow DUT pops, draw stimulus, run the model.
    task automatic step(input bit stim, input bit model_on, input bit release_rst);
        bit           ew, er, hd;
        int           dly, r;
        logic [W-1:0] word;
        exp_t         e;
        @(posedge clk_i);
        cyc++;
        #1;
        if (release_rst) begin
            rst_n_i  = 1'b1;
            in_reset = 1'b0;
        end
        if (pop_w && wq.size() != 0) void'(wq.pop_front());
        if (pop_r && rq.size() != 0) void'(rq.pop_front());

        if (stim) begin
            if (wq.size() < 3 && $urandom_range(0, 3) == 0) wq.push_back($urandom());
            if (rq.size() < 3 && $urandom_range(0, 3) == 0) rq.push_back($urandom());
            if ($urandom_range(0, 15) == 0) full_mode = !full_mode;
            rsp_full_i = full_mode ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
        end else begin
            rsp_full_i = 1'b0;
        end

        spi_done_i    = 1'b0;
        spi_rx_data_i = $urandom();
        if (in_xfer && m_has_done && cyc == m_done) begin
            spi_done_i    = 1'b1;
            spi_rx_data_i = m_rx;
        end else if (!(in_xfer && cyc >= m_g + 2 && cyc <= m_end)
                     && $urandom_range(0, 7) == 0) begin
            spi_done_i = 1'b1;  // stray done, must be ignored
        end

        wr_cmd_valid_i = (wq.size() != 0);
        wr_cmd_data_i  = (wq.size() != 0) ? wq[0] : '0;
        rd_cmd_valid_i = (rq.size() != 0);
        rd_cmd_data_i  = (rq.size() != 0) ? rq[0] : '0;

        if (!model_on) begin
            exp_busy = 1'b0;
            return;
        end

        if (in_xfer && cyc == m_free) in_xfer = 1'b0;
        exp_busy = in_xfer;
        if (in_xfer && m_rsp_pend && cyc > m_done && !rsp_full_i) begin
            e.cyc = cyc; e.data = m_rx; e.rd = 1'b1;
            exp_rsp.push_back(e);
            m_rsp_pend = 1'b0;
            m_free     = cyc + 1;
        end
        if (!in_xfer) begin
            ew = (wq.size() != 0);
            er = (rq.size() != 0) && !rsp_full_i;
            if (ew || er) begin
                m_rd      = er && (!ew || !m_last_rd);
                m_last_rd = m_rd;
                word      = m_rd ? rq[0] : wq[0];
                e.cyc = cyc; e.data = word; e.rd = m_rd;
                exp_pop.push_back(e);
                e.cyc = cyc + 2;
                exp_start.push_back(e);
                m_g        = cyc;
                in_xfer    = 1'b1;
                m_rsp_pend = 1'b0;
                r  = $urandom_range(0, 9);
                hd = !force_nodone && (r <= 7);
                dly = (r <= 5) ? $urandom_range(0, 6) : ((r == 6) ? T - 1 : T);
                m_has_done = hd;
                if (hd) begin
                    m_done = cyc + 2 + dly;
                    m_end  = m_done;
                    m_rx   = $urandom();
                    if (m_rd) begin
                        m_rsp_pend = 1'b1;
                        m_free     = Never;
                    end else begin
                        m_free = m_done + 1;
                    end
                end else begin
                    m_done = Never;
                    m_end  = cyc + 2 + T;
                    e.cyc = m_end; e.data = '0; e.rd = m_rd;
                    exp_to.push_back(e);
                    m_free = m_end + 1;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0 || in_xfer) && n < 600) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        if (n >= 600) note_missing("drain_idle", cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_start"}, 64'(spi_start_o), 64'd0);
        chk({tag, "_wr_pop"}, 64'(wr_cmd_rd_o), 64'd0);
        chk({tag, "_rd_pop"}, 64'(rd_cmd_rd_o), 64'd0);
        chk({tag, "_rsp_wr"}, 64'(rsp_wr_o), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
        chk({tag, "_tx_data"}, 64'(spi_tx_data_o), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data_o), 64'd0);
        chk({tag, "_grant_rd"}, 64'(grant_rd_o), 64'd1);
    endtask

    initial begin
        int n;
        #1 rst_n_i = 1'b0;
        #1 check_reset_outputs("por");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) step(1'b1, 1'b1, 1'b0);
        drain();

        // Reset in the middle of a read's wait phase.
        rq.push_back(32'h8000_0010);
        force_nodone = 1'b1;
        n = 0;
        while (!(in_xfer && m_rd && cyc == m_g + 5) && n < 40) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) note_missing("reach_read_wait", cyc);
        #3 rst_n_i = 1'b0;
        in_reset = 1'b1;
        #1 check_reset_outputs("mid");
        exp_pop.delete();
        exp_start.delete();
        exp_rsp.delete();
        exp_to.delete();
        in_xfer      = 1'b0;
        m_last_rd    = 1'b1;
        force_nodone = 1'b0;
        wq.push_back(32'hA5A5_0001);
        rq.push_back(32'h8000_0020);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        drain();

        for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b0);
        drain();

        chk("leftover_pop", 64'(exp_pop.size()), 64'd0);
        chk("leftover_start", 64'(exp_start.size()), 64'd0);
        chk("leftover_rsp", 64'(exp_rsp.size()), 64'd0);
        chk("leftover_timeout", 64'(exp_to.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
